i2s_rx: RTL and testbench

//  I2S receiver for an external master (e.g. CS5343 ADC, or loopback of our TX).

---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_pin_sync.sv | 48 ++++
 rtl/i2s_rx.sv | 165 ++++++++++++++++
 tb/tb_i2s_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared states and word-select encodings for the I2S receiver
package i2s_pkg;

  typedef enum logic [1:0] {
    UNLOCKED,
    LEFT,
    RIGHT
  } i2s_rx_state_t;

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_pin_sync.sv
// rtl/i2s_pin_sync.sv - pin synchronizers plus sclk edge detect for the I2S receiver
module i2s_pin_sync
  import i2s_pkg::*;
#(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk_in,
  input  logic lrclk_in,
  input  logic sd_in,
  output logic sclk_rise,
  output logic lrclk_s,
  output logic sd_s
);

  logic [SYNC_FF-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_FF-1:0] lrclk_sync_q, lrclk_sync_d;
  logic [SYNC_FF-1:0] sd_sync_q, sd_sync_d;
  logic               sclk_hist_q, sclk_hist_d;

  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_FF-2:0], sclk_in};
    lrclk_sync_d = {lrclk_sync_q[SYNC_FF-2:0], lrclk_in};
    sd_sync_d    = {sd_sync_q[SYNC_FF-2:0], sd_in};
    sclk_hist_d  = sclk_sync_q[SYNC_FF-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      lrclk_sync_q <= '0;
      sd_sync_q    <= '0;
      sclk_hist_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      lrclk_sync_q <= lrclk_sync_d;
      sd_sync_q    <= sd_sync_d;
      sclk_hist_q  <= sclk_hist_d;
    end
  end

  // lrclk and sd come from the same stage as the sclk edge so all three see equal skew
  assign sclk_rise = sclk_sync_q[SYNC_FF-1] & ~sclk_hist_q;
  assign lrclk_s   = lrclk_sync_q[SYNC_FF-1];
  assign sd_s      = sd_sync_q[SYNC_FF-1];

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - oversampling Philips I2S receiver delivering stereo sample pairs
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_BIT    = 16,
  parameter int SYNC_FF     = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx_sclk,
  input  logic                rx_lrclk,
  input  logic                rx_sd,
  output logic [DATA_BIT-1:0] audio_l,
  output logic [DATA_BIT-1:0] audio_r,
  output logic                valid,
  output logic                locked,
  output logic                frame_err
);

  localparam int CW = $clog2(DATA_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic sclk_rise, lrclk_s, sd_s;

  i2s_pin_sync #(.SYNC_FF(SYNC_FF)) u_pin_sync (
    .clk      (clk),
    .reset    (reset),
    .sclk_in  (rx_sclk),
    .lrclk_in (rx_lrclk),
    .sd_in    (rx_sd),
    .sclk_rise(sclk_rise),
    .lrclk_s  (lrclk_s),
    .sd_s     (sd_s)
  );

  i2s_rx_state_t       state_q, state_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [DATA_BIT-1:0] shreg_q, shreg_d;
  logic [DATA_BIT-1:0] left_hold_q, left_hold_d;
  logic [DATA_BIT-1:0] audio_l_q, audio_l_d;
  logic [DATA_BIT-1:0] audio_r_q, audio_r_d;
  logic                lr_prev_q, lr_prev_d;
  logic                left_ok_q, left_ok_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                frame_err_q, frame_err_d;
  logic                lr_chg, timeout, slot_full;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tmr_d       = tmr_q;
    shreg_d     = shreg_q;
    left_hold_d = left_hold_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    lr_prev_d   = lr_prev_q;
    left_ok_d   = left_ok_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    lr_chg    = sclk_rise && (lrclk_s != lr_prev_q);
    timeout   = !sclk_rise && (tmr_q >= TW'(TIMEOUT_CYC - 1));
    slot_full = (bit_cnt_q == CW'(DATA_BIT));

    if (sclk_rise) begin
      tmr_d     = '0;
      lr_prev_d = lrclk_s;
      if (lr_chg) begin
        bit_cnt_d = '0;
      end else if (!slot_full) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shreg_d   = {shreg_q[DATA_BIT-2:0], sd_s};
      end
    end else if (tmr_q != TW'(TIMEOUT_CYC)) begin
      tmr_d = tmr_q + 1'b1;
    end

    if (timeout) begin
      state_d   = UNLOCKED;
      left_ok_d = 1'b0;
    end else if (lr_chg) begin
      case (state_q)
        UNLOCKED: begin
          if (lrclk_s == LR_LEFT) state_d = LEFT;
        end
        LEFT: begin
          if (lrclk_s == LR_RIGHT) begin
            if (slot_full) begin
              left_hold_d = shreg_q;
              left_ok_d   = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              left_ok_d   = 1'b0;
            end
            state_d = RIGHT;
          end else begin
            frame_err_d = 1'b1;
            left_ok_d   = 1'b0;
            state_d     = UNLOCKED;
          end
        end
        RIGHT: begin
          if (lrclk_s == LR_LEFT) begin
            if (slot_full && left_ok_q) begin
              audio_l_d = left_hold_q;
              audio_r_d = shreg_q;
              valid_d   = 1'b1;
            end else if (!slot_full) begin
              frame_err_d = 1'b1;
            end
            left_ok_d = 1'b0;
            state_d   = LEFT;
          end else begin
            frame_err_d = 1'b1;
            left_ok_d   = 1'b0;
            state_d     = UNLOCKED;
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    locked_d = (state_d != UNLOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= UNLOCKED;
      bit_cnt_q   <= '0;
      tmr_q       <= '0;
      shreg_q     <= '0;
      left_hold_q <= '0;
      audio_l_q   <= '0;
      audio_r_q   <= '0;
      lr_prev_q   <= 1'b0;
      left_ok_q   <= 1'b0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tmr_q       <= tmr_d;
      shreg_q     <= shreg_d;
      left_hold_q <= left_hold_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      lr_prev_q   <= lr_prev_d;
      left_ok_q   <= left_ok_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign audio_l   = audio_l_q;
  assign audio_r   = audio_r_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - self-checking bench for i2s_rx driven by an I2S master pin model
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_sclk, rx_lrclk, rx_sd;
  logic [15:0] audio_l, audio_r;
  logic        valid, locked, frame_err;

  int          checks = 0;
  int          failures = 0;
  int          ferr_cnt = 0;
  logic [31:0] sb[$];
  logic        carry;

  i2s_rx #(.DATA_BIT(16), .SYNC_FF(2), .TIMEOUT_CYC(256)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_sclk  (rx_sclk),
    .rx_lrclk (rx_lrclk),
    .rx_sd    (rx_sd),
    .audio_l  (audio_l),
    .audio_r  (audio_r),
    .valid    (valid),
    .locked   (locked),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: each valid pops the oldest expected {left, right} pair
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (valid) begin
        logic [31:0] exp_pair;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got L=%h R=%h, required no valid", audio_l, audio_r);
        end else begin
          exp_pair = sb.pop_front();
          if ({audio_l, audio_r} !== exp_pair) begin
            failures++;
            $display("FAIL sample_pair: got L=%h R=%h, required L=%h R=%h",
                     audio_l, audio_r, exp_pair[31:16], exp_pair[15:0]);
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One sclk period of ~650 ns (65 clk); pins change while sclk is low
  task automatic sclk_cycle(input logic lr, input logic sd);
    rx_sclk  = 1'b0;
    rx_lrclk = lr;
    rx_sd    = sd;
    repeat (33) @(posedge clk);
    #2;
    rx_sclk = 1'b1;
    repeat (32) @(posedge clk);
    #2;
  endtask

  // Philips slot: first bit carries the previous word's tail, word MSB-first follows
  task automatic send_slot(input logic lr, input logic [31:0] word, input int nb, input int slen);
    logic b;
    for (int k = 0; k < slen; k++) begin
      if (k == 0) b = carry;
      else if (k - 1 < nb) b = word[31-(k-1)];
      else b = 1'b0;
      sclk_cycle(lr, b);
    end
    carry = (nb >= slen && slen >= 1) ? word[31-(slen-1)] : 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb,
                            input int ls, input int rs);
    send_slot(1'b0, l, nb, ls);
    send_slot(1'b1, r, nb, rs);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset    = 1'b1;
    rx_sclk  = 1'b0;
    rx_lrclk = 1'b0;
    rx_sd    = 1'b0;
    carry    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic finish_test(input string name, input int base, input int exp_ferr,
                             input logic exp_locked);
    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_valid: got %0d pairs outstanding, required 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (ferr_cnt - base != exp_ferr) begin
      failures++;
      $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, ferr_cnt - base, exp_ferr);
    end
    checks++;
    if (locked !== exp_locked) begin
      failures++;
      $display("FAIL %s_locked: got %b, required %b", name, locked, exp_locked);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    rx_sclk  = 1'b0;
    rx_lrclk = 1'b1;
    rx_sd    = 1'b1;
    carry    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (audio_l !== 16'h0) begin failures++; $display("FAIL reset_audio_l: got %h, required 0000", audio_l); end
    checks++;
    if (audio_r !== 16'h0) begin failures++; $display("FAIL reset_audio_r: got %h, required 0000", audio_r); end
    checks++;
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b, required 0", locked); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    do_reset();
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = ferr_cnt;
    send_frame(32'h1111_0000, 32'h2222_0000, 16, 17, 17);
    sb.push_back({16'hA5C3, 16'h1234});
    send_frame(32'hA5C3_0000, 32'h1234_0000, 16, 17, 17);
    sb.push_back({16'h5A3C, 16'hEDCB});
    send_frame(32'h5A3C_0000, 32'hEDCB_0000, 16, 17, 17);
    send_slot(1'b0, 32'h0, 16, 1);
    finish_test("basic", base, 0, 1'b1);
  endtask

  task automatic test_wide();
    int base;
    do_reset();
    base = ferr_cnt;
    send_frame(32'h8001_FFFF, 32'h7FFE_0000, 32, 32, 32);
    sb.push_back({16'h8001, 16'h7FFE});
    send_frame(32'h8001_FFFF, 32'h7FFE_0000, 32, 32, 32);
    sb.push_back({16'h8001, 16'h7FFE});
    send_frame(32'h8001_FFFF, 32'h7FFE_0000, 32, 32, 32);
    send_slot(1'b0, 32'h0, 16, 1);
    finish_test("wide", base, 0, 1'b1);
  endtask

  task automatic test_short_slot();
    int base;
    do_reset();
    base = ferr_cnt;
    send_frame(32'h1111_0000, 32'h2222_0000, 16, 17, 17);
    send_frame(32'hA5C3_0000, 32'h1234_0000, 16, 11, 17);
    sb.push_back({16'hC0DE, 16'hBEEF});
    send_frame(32'hC0DE_0000, 32'hBEEF_0000, 16, 17, 17);
    send_frame(32'h4444_0000, 32'h5555_0000, 16, 17, 16);
    send_slot(1'b0, 32'h0, 16, 1);
    finish_test("short_slot", base, 2, 1'b1);
  endtask

  task automatic test_timeout();
    int base;
    int n;
    do_reset();
    base = ferr_cnt;
    send_frame(32'h1111_0000, 32'h2222_0000, 16, 17, 17);
    sb.push_back({16'h3333, 16'h4444});
    send_frame(32'h3333_0000, 32'h4444_0000, 16, 17, 17);
    rx_sclk  = 1'b0;
    rx_lrclk = 1'b0;
    rx_sd    = carry;
    repeat (33) @(posedge clk);
    #2;
    rx_sclk = 1'b1;
    n = 0;
    while (n < 400) begin
      @(posedge clk);
      n++;
      if (n == 32) begin
        #2;
        rx_sclk = 1'b0;
      end
      @(negedge clk);
      if (!locked) break;
    end
    checks++;
    if (n < 258 || n > 260) begin
      failures++;
      $display("FAIL timeout_cycles: locked dropped %0d clk after last sclk edge, required 258..260", n);
    end
    repeat (40) @(posedge clk);
    #2;
    carry = 1'b0;
    send_frame(32'h6666_0000, 32'h7777_0000, 16, 17, 17);
    sb.push_back({16'h9ABC, 16'hDEF0});
    send_frame(32'h9ABC_0000, 32'hDEF0_0000, 16, 17, 17);
    send_slot(1'b0, 32'h0, 16, 1);
    finish_test("timeout", base, 0, 1'b1);
  endtask

  task automatic test_mid_start();
    int base;
    do_reset();
    base = ferr_cnt;
    send_slot(1'b1, 32'hDEAD_0000, 16, 8);
    sb.push_back({16'h0F0F, 16'hF00F});
    send_frame(32'h0F0F_0000, 32'hF00F_0000, 16, 17, 17);
    send_slot(1'b0, 32'h0, 16, 1);
    finish_test("mid_start", base, 0, 1'b1);
  endtask

  task automatic test_reset_mid_slot();
    int base;
    do_reset();
    base = ferr_cnt;
    send_frame(32'h1111_0000, 32'h2222_0000, 16, 17, 17);
    sb.push_back({16'hA5C3, 16'h1234});
    send_frame(32'hA5C3_0000, 32'h1234_0000, 16, 17, 17);
    send_slot(1'b0, 32'h9999_0000, 16, 6);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (audio_l !== 16'h0 || audio_r !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_audio: got L=%h R=%h, required 0000/0000", audio_l, audio_r);
    end
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_locked: got %b, required 0", locked);
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    carry = 1'b0;
    send_slot(1'b0, 32'h9999_0000, 16, 10);
    send_slot(1'b1, 32'h8888_0000, 16, 17);
    sb.push_back({16'h1357, 16'h2468});
    send_frame(32'h1357_0000, 32'h2468_0000, 16, 17, 17);
    send_slot(1'b0, 32'h0, 16, 1);
    finish_test("reset_mid", base, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_short_slot();
    test_timeout();
    test_mid_start();
    test_reset_mid_slot();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
